// File: rtl/rst_cipher_pkg.sv
// Shared definitions for the RST rotating-table cipher (used by rst_decipher and init_table).
// Optional feature macro used by the top: RST_DECIPHER_REKEY_EN.
package rst_cipher_pkg;

  localparam int KEY_LEN = 12;
  localparam int HDR_N   = 6;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LZ  = 8'h7a;
  localparam logic [7:0] CH_UA  = 8'h41;
  localparam logic [7:0] CH_UZ  = 8'h5a;
  localparam logic [7:0] CH_D0  = 8'h30;
  localparam logic [7:0] CH_D9  = 8'h39;

  typedef logic [HDR_N-1:0][7:0] hdr_t;

  typedef enum logic [1:0] {
    KEY_WAIT  = 2'd0,
    KEY_CHECK = 2'd1,
    READY     = 2'd2
  } state_e;

  function automatic logic is_alnum(input logic [7:0] ch);
    return ((ch >= CH_LA) && (ch <= CH_LZ)) ||
           ((ch >= CH_UA) && (ch <= CH_UZ)) ||
           ((ch >= CH_D0) && (ch <= CH_D9));
  endfunction

  // Row/col are 0-based here; table fills 'a'..'z' then '0'..'9' row-major.
  function automatic logic [7:0] body_char(input logic [2:0] r, input logic [2:0] c);
    logic [5:0] idx;
    idx = 6'(r) * 6'd6 + 6'(c);
    if (idx < 6'd26) return CH_LA + 8'(idx);
    else             return CH_D0 + 8'(idx - 6'd26);
  endfunction

endpackage

// File: rtl/rst_key_checker.sv
// Serial key validator: one key position per cycle, tested for alnum and uniqueness.
module rst_key_checker
  import rst_cipher_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       active_i,
  input  logic [8*KEY_LEN-1:0]       key_i,
  output logic [KEY_LEN-1:0][7:0]    key_o,
  output logic                       done_o,
  output logic                       key_err_o
);

  logic [KEY_LEN-1:0][7:0] key_q;
  logic [3:0]              idx_q, idx_d;
  logic [7:0]              cur;
  logic                    dup;

  // key_q[i] holds key char k[i]; k[0] arrives in the top byte.
  always_ff @(posedge clk) begin
    if (start_i) begin
      for (int i = 0; i < KEY_LEN; i++) key_q[i] <= key_i[8*(KEY_LEN-1-i) +: 8];
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (start_i)       idx_d = 4'd0;
    else if (active_i) idx_d = idx_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= 4'd0;
    else     idx_q <= idx_d;
  end

  always_comb begin
    cur = key_q[idx_q];
    dup = 1'b0;
    for (int j = 0; j < KEY_LEN; j++) begin
      if ((4'(j) != idx_q) && (key_q[j] == cur)) dup = 1'b1;
    end
    key_err_o = active_i && (!is_alnum(cur) || dup);
    done_o    = active_i && !key_err_o && (idx_q == 4'(KEY_LEN-1));
  end

  assign key_o = key_q;

endmodule

// File: rtl/rst_decipher.sv
// RST decipher top: key FSM, rotating row/col header registers, CAM lookup, registered outputs.
// Optional rekey from READY is enabled by defining RST_DECIPHER_REKEY_EN.
module rst_decipher
  import rst_cipher_pkg::*;
#(
  parameter int ROT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*KEY_LEN-1:0] key_char,
  input  logic                 key_valid,
  input  logic [15:0]          ctxt_str,
  input  logic                 ctxt_valid,
  output logic [7:0]           ptxt_char,
  output logic                 ptxt_ready,
  output logic                 key_installed,
  output logic                 err_invalid_key,
  output logic                 err_key_not_installed,
  output logic                 err_invalid_ctxt
);

`ifdef RST_DECIPHER_REKEY_EN
  localparam bit REKEY_EN = 1'b1;
`else
  localparam bit REKEY_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  hdr_t                    rows_q, rows_d, cols_q, cols_d;
  logic [7:0]              ptxt_q, ptxt_d;
  logic                    rdy_q, rdy_d, ekey_q, ekey_d, enk_q, enk_d, ectx_q, ectx_d;
  logic                    start, key_done, key_err;
  logic [KEY_LEN-1:0][7:0] key;
  logic                    row_hit, col_hit;
  logic [2:0]              row_idx, col_idx;
  int                      src;

  assign start = key_valid && ((state_q != READY) || REKEY_EN);

  rst_key_checker u_chk (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .active_i  (state_q == KEY_CHECK),
    .key_i     (key_char),
    .key_o     (key),
    .done_o    (key_done),
    .key_err_o (key_err)
  );

  // Key chars are unique once installed, so at most one row and one col can hit.
  always_comb begin
    row_hit = 1'b0;
    col_hit = 1'b0;
    row_idx = 3'd0;
    col_idx = 3'd0;
    for (int i = 0; i < HDR_N; i++) begin
      if (rows_q[i] == ctxt_str[15:8]) begin row_hit = 1'b1; row_idx = 3'(i); end
      if (cols_q[i] == ctxt_str[7:0])  begin col_hit = 1'b1; col_idx = 3'(i); end
    end
  end

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    ptxt_d  = CH_NUL;
    rdy_d   = 1'b0;
    enk_d   = 1'b0;
    ectx_d  = 1'b0;
    ekey_d  = ekey_q;
    src     = 0;
    if (start) begin
      state_d = KEY_CHECK;
      ekey_d  = 1'b0;
    end else if (state_q == KEY_CHECK) begin
      if (key_err) begin
        state_d = KEY_WAIT;
        ekey_d  = 1'b1;
      end else if (key_done) begin
        state_d = READY;
        // Rows take even positions ascending and odd positions descending; cols are the partners.
        for (int i = 0; i < HDR_N; i++) begin
          src       = (i % 2 == 0) ? i : (KEY_LEN - 1 - i);
          rows_d[i] = key[src];
          cols_d[i] = key[src + 1];
        end
      end
    end
    if (ctxt_valid) begin
      if ((state_q != READY) || start) begin
        enk_d = 1'b1;
      end else if (row_hit && col_hit) begin
        ptxt_d = body_char(row_idx, col_idx);
        rdy_d  = 1'b1;
        for (int i = 0; i < HDR_N; i++) begin
          src       = (i + HDR_N - ROT_STEP) % HDR_N;
          rows_d[i] = rows_q[src];
          cols_d[i] = cols_q[src];
        end
      end else begin
        ectx_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= KEY_WAIT;
      rows_q  <= '0;
      cols_q  <= '0;
      ptxt_q  <= CH_NUL;
      rdy_q   <= 1'b0;
      ekey_q  <= 1'b0;
      enk_q   <= 1'b0;
      ectx_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      ptxt_q  <= ptxt_d;
      rdy_q   <= rdy_d;
      ekey_q  <= ekey_d;
      enk_q   <= enk_d;
      ectx_q  <= ectx_d;
    end
  end

  assign ptxt_char             = ptxt_q;
  assign ptxt_ready            = rdy_q;
  assign key_installed         = (state_q == READY);
  assign err_invalid_key       = ekey_q;
  assign err_key_not_installed = enk_q;
  assign err_invalid_ctxt      = ectx_q;

endmodule

// File: tb/tb_rst_decipher.sv
// Directed bench for rst_decipher with an encoder reference model and an expected-result queue.
module tb_rst_decipher;

  localparam int RS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] key_char = '0;
  logic        key_valid = 1'b0;
  logic [15:0] ctxt_str = '0;
  logic        ctxt_valid = 1'b0;
  logic [7:0]  ptxt_char;
  logic        ptxt_ready, key_installed, err_invalid_key;
  logic        err_key_not_installed, err_invalid_ctxt;

  typedef struct packed {
    logic       rdy;
    logic [7:0] ch;
    logic       einv;
    logic       enk;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mrow[6];
  logic [7:0] mcol[6];

  rst_decipher #(.ROT_STEP(RS)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .key_char              (key_char),
    .key_valid             (key_valid),
    .ctxt_str              (ctxt_str),
    .ctxt_valid            (ctxt_valid),
    .ptxt_char             (ptxt_char),
    .ptxt_ready            (ptxt_ready),
    .key_installed         (key_installed),
    .err_invalid_key       (err_invalid_key),
    .err_key_not_installed (err_key_not_installed),
    .err_invalid_ctxt      (err_invalid_ctxt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic [7:0] ch, input logic einv, input logic enk);
    exp_t e;
    e.rdy = rdy; e.ch = ch; e.einv = einv; e.enk = enk;
    return e;
  endfunction

  function automatic logic [7:0] kb(input logic [95:0] k, input int i);
    return k[95-8*i -: 8];
  endfunction

  task automatic model_load(input logic [95:0] k);
    mrow = '{kb(k,0), kb(k,10), kb(k,2), kb(k,8), kb(k,4), kb(k,6)};
    mcol = '{kb(k,1), kb(k,11), kb(k,3), kb(k,9), kb(k,5), kb(k,7)};
  endtask

  // Reference encoder: locate char in the body, emit headers, then rotate right.
  task automatic enc(input logic [7:0] ch, output logic [15:0] pair);
    int idx;
    logic [7:0] tr[6];
    logic [7:0] tc[6];
    idx  = (ch >= 8'h61) ? int'(ch) - 8'h61 : 26 + int'(ch) - 8'h30;
    pair = {mrow[idx/6], mcol[idx%6]};
    for (int i = 0; i < 6; i++) begin
      tr[i] = mrow[(i + 6 - RS) % 6];
      tc[i] = mcol[(i + 6 - RS) % 6];
    end
    mrow = tr;
    mcol = tc;
  endtask

  task automatic send(input string tag, input logic [15:0] pair, input exp_t e);
    exp_t g;
    ctxt_str   = pair;
    ctxt_valid = 1'b1;
    sb.push_back(e);
    cyc();
    g = sb.pop_front();
    chk({tag, ".rdy"},  {15'd0, ptxt_ready},            {15'd0, g.rdy});
    chk({tag, ".char"}, {8'd0, ptxt_char},              {8'd0, g.ch});
    chk({tag, ".einv"}, {15'd0, err_invalid_ctxt},      {15'd0, g.einv});
    chk({tag, ".enk"},  {15'd0, err_key_not_installed}, {15'd0, g.enk});
  endtask

  task automatic do_reset();
    rst = 1'b1; key_valid = 1'b0; ctxt_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Returns the number of edges after key_valid until installed or rejected (99 = timeout).
  task automatic load_key(input logic [95:0] k, output int n);
    key_char = k; key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (key_installed || err_invalid_key) begin n = i; break; end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".char"}, {8'd0, ptxt_char}, 16'd0);
    chk({tag, ".rdy"},  {15'd0, ptxt_ready}, 16'd0);
    chk({tag, ".inst"}, {15'd0, key_installed}, 16'd0);
    chk({tag, ".ekey"}, {15'd0, err_invalid_key}, 16'd0);
    chk({tag, ".enk"},  {15'd0, err_key_not_installed}, 16'd0);
    chk({tag, ".ectx"}, {15'd0, err_invalid_ctxt}, 16'd0);
  endtask

  initial begin
    int          n;
    logic [15:0] p;
    logic [7:0]  ch;
    logic [95:0] key0;
    key0 = "abcdefghijkl";

    // Reset state and ctxt before any key
    do_reset();
    chk_idle("reset");
    send("nokey", "ab", mk(1'b0, 8'h00, 1'b0, 1'b1));
    ctxt_valid = 1'b0;

    // Bad keys
    load_key("abcdefghi?kl", n);
    chk("badchar.lat", 16'(n), 16'd10);
    chk("badchar.err", {15'd0, err_invalid_key}, 16'd1);
    load_key("abcdabcdabcd", n);
    chk("dup.lat", 16'(n), 16'd1);
    chk("dup.err", {15'd0, err_invalid_key}, 16'd1);
    chk("dup.inst", {15'd0, key_installed}, 16'd0);

    // Install and decode with rotation
    load_key(key0, n);
    chk("inst.lat", 16'(n), 16'd12);
    chk("inst.ekey", {15'd0, err_invalid_key}, 16'd0);
    send("ab1", "ab", mk(1'b1, "a", 1'b0, 1'b0));
    send("ab2", "ab", mk(1'b1, "h", 1'b0, 1'b0));
    ctxt_valid = 1'b0;
    cyc();
    chk("pulse.rdy", {15'd0, ptxt_ready}, 16'd0);
    chk("pulse.char", {8'd0, ptxt_char}, 16'd0);

    // Corner of the table, then wrap to first row/col
    do_reset();
    load_key(key0, n);
    chk("inst2.lat", 16'(n), 16'd12);
    send("gh1", "gh", mk(1'b1, "9", 1'b0, 1'b0));
    send("gh2", "gh", mk(1'b1, "a", 1'b0, 1'b0));
    ctxt_valid = 1'b0;

    // Invalid pair must not rotate
    do_reset();
    load_key(key0, n);
    model_load(key0);
    send("zz", "zz", mk(1'b0, 8'h00, 1'b1, 1'b0));
    enc("a", p);
    send("after_zz", p, mk(1'b1, "a", 1'b0, 1'b0));
    ctxt_valid = 1'b0;

`ifndef RST_DECIPHER_REKEY_EN
    // key_valid while READY is ignored
    load_key("zyxwvutsrqpo", n);
    chk("norekey.inst", {15'd0, key_installed}, 16'd1);
    chk("norekey.ekey", {15'd0, err_invalid_key}, 16'd0);
    enc("q", p);
    send("norekey.q", p, mk(1'b1, "q", 1'b0, 1'b0));
    ctxt_valid = 1'b0;
`else
    // key_valid while READY takes priority over ctxt
    key_char = "zyxwvutsrqpo"; key_valid = 1'b1;
    send("rekey.ctxt", "ab", mk(1'b0, 8'h00, 1'b0, 1'b1));
    key_valid = 1'b0; ctxt_valid = 1'b0;
    chk("rekey.inst", {15'd0, key_installed}, 16'd0);
`endif

    // Loop-back full alphabet, back-to-back
    do_reset();
    load_key(key0, n);
    model_load(key0);
    for (int i = 0; i < 36; i++) begin
      ch = (i < 26) ? 8'(8'h61 + i) : 8'(8'h30 + i - 26);
      enc(ch, p);
      send($sformatf("loop%0d", i), p, mk(1'b1, ch, 1'b0, 1'b0));
    end
    ctxt_valid = 1'b0;
    cyc();
    chk("loop.end", {15'd0, ptxt_ready}, 16'd0);

    // Reset in the middle of a key check
    do_reset();
    key_char = key0; key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    repeat (5) cyc();
    #2 rst = 1'b1;
    #1 chk_idle("midrst");
    cyc();
    rst = 1'b0;
    repeat (15) cyc();
    chk("midrst.inst", {15'd0, key_installed}, 16'd0);
    load_key(key0, n);
    chk("midrst.relat", 16'(n), 16'd12);
    send("midrst.ab", "ab", mk(1'b1, "a", 1'b0, 1'b0));
    ctxt_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
